// File: rtl/pdm_bank_pkg.sv
// ============================================================================
// Module      : pdm_bank_pkg
// Description : Register map constants and shared types for the pdm_bank
//               Wishbone PDM output bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pdm_bank_pkg;
    localparam int ADR_ENABLE   = 32;
    localparam int ADR_PRESCALE = 33;
    localparam int MAX_CHANNELS = 32;
    localparam int MAX_BITS     = 16;

    typedef logic [15:0] prescale_t;
endpackage

`default_nettype wire

// File: rtl/pdm_bank_wb_if.sv
// ============================================================================
// Module      : iWishbone
// Description : Single-clock Wishbone bundle; mPeri is the peripheral view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iWishbone;
    logic        clk;
    logic        rst;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_c;
    logic [31:0] dat_p;
    logic        ack;

    modport mPeri (input clk, rst, stb, we, adr, dat_c, output dat_p, ack);
    modport mCtrl (output clk, rst, stb, we, adr, dat_c, input dat_p, ack);
endinterface

`default_nettype wire

// File: rtl/pdm_bank_channel.sv
// ============================================================================
// Module      : pdm_bank_channel
// Description : One PDM channel: target/current level, optional ramp step,
//               first-order error accumulator. Ramp built when
//               PDM_BANK_RAMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_bank_channel
    import pdm_bank_pkg::*;
#(
    parameter int pBits = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    input  logic             wr,
    input  logic [pBits-1:0] data,
    output logic             pdm,
    output logic [pBits-1:0] target,
    output logic [pBits-1:0] current
);

    logic [pBits-1:0] target_q;
    logic [pBits-1:0] current_q;
    logic [pBits-1:0] current_d;
    logic [pBits:0]   acc_q;
    logic [pBits:0]   w_sum;

    assign w_sum = {1'b0, acc_q[pBits-1:0]} + {1'b0, current_q};

`ifdef PDM_BANK_RAMP_EN
    always_comb begin
        current_d = current_q;
        if (tick && (current_q < target_q)) begin
            current_d = current_q + pBits'(1);
        end else if (tick && (current_q > target_q)) begin
            current_d = current_q - pBits'(1);
        end
    end
`else
    logic w_unused_tick;
    assign w_unused_tick = tick;

    always_comb begin
        current_d = wr ? data : target_q;
    end
`endif

    // The carry of the last sum lives in acc_q's top bit, so it is the pdm bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q  <= '0;
            current_q <= '0;
            acc_q     <= '0;
        end else begin
            if (wr) begin
                target_q <= data;
            end
            current_q <= current_d;
            acc_q     <= en ? w_sum : '0;
        end
    end

    assign pdm     = acc_q[pBits];
    assign target  = target_q;
    assign current = current_q;

endmodule

`default_nettype wire

// File: rtl/pdm_bank.sv
// ============================================================================
// Module      : pdm_bank
// Description : Wishbone multi-channel PDM output bank with enable mask and
//               optional slew limiter (macro PDM_BANK_RAMP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_bank
    import pdm_bank_pkg::*;
#(
    parameter int pBits     = 8,
    parameter int pChannels = 1
) (
    iWishbone.mPeri              wb,
    output logic [pChannels-1:0] pdm
);

    logic                 w_accept;
    logic                 w_wr;
    logic                 w_tick;
    logic [31:0]          w_rd_d;
    logic [pChannels-1:0] w_ch_wr;
    logic [pBits-1:0]     w_target  [pChannels];
    logic [pBits-1:0]     w_current [pChannels];
    logic [pChannels-1:0] enable_q;
    logic                 ack_q;
    logic [31:0]          dat_p_q;
    logic                 w_unused_dat;

    assign w_accept     = wb.stb & ~ack_q;
    assign w_wr         = w_accept & wb.we;
    assign w_unused_dat = ^wb.dat_c;

    for (genvar n = 0; n < pChannels; n++) begin : g_ch
        assign w_ch_wr[n] = w_wr && (wb.adr == 32'(n));

        pdm_bank_channel #(
            .pBits (pBits)
        ) u_ch (
            .clk     (wb.clk),
            .rst     (wb.rst),
            .en      (enable_q[n]),
            .tick    (w_tick),
            .wr      (w_ch_wr[n]),
            .data    (wb.dat_c[pBits-1:0]),
            .pdm     (pdm[n]),
            .target  (w_target[n]),
            .current (w_current[n])
        );
    end

`ifdef PDM_BANK_RAMP_EN
    prescale_t prescale_q;
    prescale_t tick_cnt_q;

    // >= rather than == so a PRESCALE lowered below the count wraps at once.
    assign w_tick = (tick_cnt_q >= prescale_q);

    always_ff @(posedge wb.clk) begin
        if (wb.rst) begin
            prescale_q <= '0;
            tick_cnt_q <= '0;
        end else begin
            if (w_wr && (wb.adr == 32'(ADR_PRESCALE))) begin
                prescale_q <= wb.dat_c[15:0];
            end
            tick_cnt_q <= w_tick ? '0 : tick_cnt_q + 16'd1;
        end
    end
`else
    assign w_tick = 1'b0;
`endif

    always_comb begin
        w_rd_d = '0;
        for (int n = 0; n < pChannels; n++) begin
            if (wb.adr == 32'(n)) begin
                w_rd_d = {16'(w_current[n]), 16'(w_target[n])};
            end
        end
        if (wb.adr == 32'(ADR_ENABLE)) begin
            w_rd_d = 32'(enable_q);
        end
`ifdef PDM_BANK_RAMP_EN
        if (wb.adr == 32'(ADR_PRESCALE)) begin
            w_rd_d = 32'(prescale_q);
        end
`endif
    end

    always_ff @(posedge wb.clk) begin
        if (wb.rst) begin
            enable_q <= '0;
            ack_q    <= 1'b0;
            dat_p_q  <= '0;
        end else begin
            if (w_wr && (wb.adr == 32'(ADR_ENABLE))) begin
                enable_q <= wb.dat_c[pChannels-1:0];
            end
            ack_q   <= w_accept;
            dat_p_q <= w_accept ? w_rd_d : '0;
        end
    end

    assign wb.ack   = ack_q;
    assign wb.dat_p = dat_p_q;

endmodule

`default_nettype wire

// File: tb/tb_pdm_bank.sv
// ============================================================================
// Module      : tb_pdm_bank
// Description : Self-checking bench for pdm_bank (pBits=8, pChannels=4);
//               ramp scenario built when PDM_BANK_RAMP_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdm_bank;
    localparam int BITS = 8;
    localparam int CH   = 4;
    localparam int FULL = 1 << BITS;

    logic          clk = 1'b0;
    logic [CH-1:0] pdm;
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;

    iWishbone wb_if();
    assign wb_if.clk = clk;

    pdm_bank #(
        .pBits     (BITS),
        .pChannels (CH)
    ) dut (
        .wb  (wb_if),
        .pdm (pdm)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // k-th output bit (k >= 1) of an ideal modulator started from zero error.
    function automatic logic exp_bit(input int c, input int k);
        return (((k * c) / FULL) - (((k - 1) * c) / FULL)) != 0;
    endfunction

    task automatic wb_xfer(input logic we, input int adr, input int dat,
                           output logic [31:0] rdata, output logic ack_seen, output int edge_idx);
        @(negedge clk);
        wb_if.stb   = 1'b1;
        wb_if.we    = we;
        wb_if.adr   = 32'(adr);
        wb_if.dat_c = 32'(dat);
        @(posedge clk);
        @(negedge clk);
        wb_if.stb = 1'b0;
        wb_if.we  = 1'b0;
        rdata     = wb_if.dat_p;
        ack_seen  = wb_if.ack;
        edge_idx  = cyc;
    endtask

    task automatic wb_write(input int adr, input int dat);
        logic [31:0] r;
        logic        a;
        int          e;
        wb_xfer(1'b1, adr, dat, r, a, e);
    endtask

    task automatic wb_read(input int adr, output logic [31:0] r);
        logic a;
        int   e;
        wb_xfer(1'b0, adr, 0, r, a, e);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        wb_if.rst = 1'b1;
        wb_if.stb = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (pdm !== '0) begin errors++; $display("FAIL reset_pdm got %h want 0", pdm); end
        checks++; if (wb_if.ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", wb_if.ack); end
        checks++; if (wb_if.dat_p !== 32'h0) begin errors++; $display("FAIL reset_datp got %h want 0", wb_if.dat_p); end
        wb_if.stb = 1'b1;
        wb_if.we  = 1'b0;
        wb_if.adr = 32'd0;
        @(negedge clk);
        checks++; if (wb_if.ack !== 1'b0) begin errors++; $display("FAIL ack_in_reset got %b want 0", wb_if.ack); end
        wb_if.rst = 1'b0;
        @(negedge clk);
        checks++; if (wb_if.ack !== 1'b1) begin errors++; $display("FAIL ack_after_release got %b want 1", wb_if.ack); end
        checks++; if (wb_if.dat_p !== 32'h0) begin errors++; $display("FAIL ch0_reset_read got %h want 0", wb_if.dat_p); end
        wb_if.stb = 1'b0;
        @(negedge clk);
        checks++; if (wb_if.ack !== 1'b0) begin errors++; $display("FAIL ack_width got %b want 0", wb_if.ack); end
        wb_read(32, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL enable_reset got %h want 0", r); end
        wb_read(33, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL prescale_reset got %h want 0", r); end
    endtask

    task automatic test_regs();
        logic [31:0] r;
        wb_write(7, 5);
        wb_write(40, 5);
        wb_read(7, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL ch7_read got %h want 0", r); end
        wb_read(40, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL adr40_read got %h want 0", r); end
        for (int ch = 0; ch < CH; ch++) begin
            wb_read(ch, r);
            checks++; if (r !== 32'h0) begin errors++; $display("FAIL ch%0d_untouched got %h want 0", ch, r); end
        end
        wb_write(32, 'hFF);
        wb_read(32, r);
        checks++; if (r !== 32'h0F) begin errors++; $display("FAIL enable_mask got %h want 0f", r); end
        wb_write(32, 0);
        wb_write(33, 'h1234);
        wb_read(33, r);
`ifdef PDM_BANK_RAMP_EN
        checks++; if (r !== 32'h1234) begin errors++; $display("FAIL prescale_rw got %h want 1234", r); end
`else
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL prescale_absent got %h want 0", r); end
`endif
        wb_write(33, 0);
        wb_read(34, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL adr34_read got %h want 0", r); end
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        wb_write(32, 5);
        @(negedge clk);
        wb_if.stb = 1'b1;
        wb_if.we  = 1'b0;
        wb_if.adr = 32'd32;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_ack = (i % 2 == 0);
            checks++; if (wb_if.ack !== exp_ack) begin errors++; $display("FAIL b2b_ack[%0d] got %b want %b", i, wb_if.ack, exp_ack); end
            checks++; if (wb_if.dat_p !== (exp_ack ? 32'h5 : 32'h0)) begin
                errors++; $display("FAIL b2b_datp[%0d] got %h want %h", i, wb_if.dat_p, exp_ack ? 32'h5 : 32'h0);
            end
        end
        wb_if.stb = 1'b0;
        wb_write(32, 0);
    endtask

    task automatic test_duty();
        int   lvls [3] = '{64, 0, 255};
        int   lvl, ones, ones2;
        logic b;
        for (int i = 0; i < 3; i++) begin
            lvl = lvls[i];
            wb_write(32, 0);
`ifdef PDM_BANK_RAMP_EN
            wb_write(0, lvl);
            repeat (300) @(negedge clk);
            wb_write(32, 1);
`else
            wb_write(0, 0);
            wb_write(32, 1);
            wb_write(0, lvl);
`endif
            ones  = 0;
            ones2 = 0;
            for (int k = 1; k <= 2 * FULL; k++) begin
                @(negedge clk);
                b = pdm[0];
                if (k <= FULL) begin
                    ones += int'(b);
                    checks++; if (b !== exp_bit(lvl, k)) begin
                        errors++; $display("FAIL duty_bit lvl=%0d k=%0d got %b want %b", lvl, k, b, exp_bit(lvl, k));
                    end
                end else begin
                    ones2 += int'(b);
                end
            end
            checks++; if (ones !== lvl) begin errors++; $display("FAIL duty_window1 lvl=%0d got %0d want %0d", lvl, ones, lvl); end
            checks++; if (ones2 !== lvl) begin errors++; $display("FAIL duty_window2 lvl=%0d got %0d want %0d", lvl, ones2, lvl); end
        end
    endtask

    task automatic test_enable();
        int   ones;
        logic want;
        wb_write(32, 0);
        wb_write(1, 128);
        ones = 0;
        repeat (300) begin
            @(negedge clk);
            ones += int'(pdm[1]);
        end
        checks++; if (ones !== 0) begin errors++; $display("FAIL disabled_quiet got %0d ones want 0", ones); end
        wb_write(32, 2);
        checks++; if (pdm[1] !== 1'b0) begin errors++; $display("FAIL enable_k0 got %b want 0", pdm[1]); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            want = (k % 2 == 0);
            checks++; if (pdm[1] !== want) begin errors++; $display("FAIL enable_seq k=%0d got %b want %b", k, pdm[1], want); end
            checks++; if (pdm[0] !== 1'b0) begin errors++; $display("FAIL enable_other k=%0d got %b want 0", k, pdm[0]); end
        end
    endtask

    task automatic test_random();
        int          lv [CH];
        logic [3:0]  mask;
        logic [31:0] r;
        logic        want;
        for (int it = 0; it < 4; it++) begin
            mask = 4'($urandom_range(1, 15));
            for (int ch = 0; ch < CH; ch++) lv[ch] = int'($urandom_range(0, FULL - 1));
            if (it == 0) begin
                lv[0] = FULL - 1;
                lv[1] = 1;
            end
            wb_write(32, 0);
            for (int ch = 0; ch < CH; ch++) wb_write(ch, lv[ch]);
            repeat (300) @(negedge clk);
            for (int ch = 0; ch < CH; ch++) begin
                wb_read(ch, r);
                checks++; if (r !== {16'(lv[ch]), 16'(lv[ch])}) begin
                    errors++; $display("FAIL rand_readback ch=%0d got %h want %h", ch, r, {16'(lv[ch]), 16'(lv[ch])});
                end
            end
            wb_write(32, int'(mask));
            for (int k = 1; k <= 300; k++) begin
                @(negedge clk);
                for (int ch = 0; ch < CH; ch++) begin
                    want = mask[ch] ? exp_bit(lv[ch], k) : 1'b0;
                    checks++; if (pdm[ch] !== want) begin
                        errors++; $display("FAIL rand_bit it=%0d ch=%0d lvl=%0d k=%0d got %b want %b", it, ch, lv[ch], k, pdm[ch], want);
                    end
                end
            end
        end
    endtask

`ifdef PDM_BANK_RAMP_EN
    // Ticks on edges a+1..b, with PRESCALE=3 written on edge p (period 4 after p).
    function automatic int ticks(input int a, input int b, input int p);
        int n = 0;
        for (int m = a + 1; m <= b; m++) if ((m > p) && ((m - p) % 4 == 0)) n++;
        return n;
    endfunction

    function automatic int ramp_val(input int v0, input int tgt, input int e0, input int e, input int p);
        int d = ticks(e0, e, p);
        if (v0 < tgt) return (v0 + d > tgt) ? tgt : v0 + d;
        return (v0 - d < tgt) ? tgt : v0 - d;
    endfunction

    task automatic poll_ramp(input int v0, input int tgt, input int e0, input int p,
                             input int nmax, input int stop_at);
        logic [31:0] r;
        logic        a;
        int          rr, cur, exp_cur, lo, hi;
        lo = (v0 < tgt) ? v0 : tgt;
        hi = (v0 < tgt) ? tgt : v0;
        for (int i = 0; i < nmax; i++) begin
            wb_xfer(1'b0, 0, 0, r, a, rr);
            cur     = int'(r[31:16]);
            exp_cur = ramp_val(v0, tgt, e0, rr - 1, p);
            checks++; if (cur !== exp_cur) begin errors++; $display("FAIL ramp_current edge=%0d got %0d want %0d", rr, cur, exp_cur); end
            checks++; if (r[15:0] !== 16'(tgt)) begin errors++; $display("FAIL ramp_target got %0d want %0d", r[15:0], tgt); end
            checks++; if ((cur < lo) || (cur > hi)) begin errors++; $display("FAIL ramp_range got %0d want %0d..%0d", cur, lo, hi); end
            if (exp_cur == stop_at) break;
        end
    endtask

    task automatic test_ramp();
        logic [31:0] r;
        logic        a;
        int          p, t1, t2, t3, w, v0;
        wb_if.rst = 1'b1;
        repeat (2) @(negedge clk);
        wb_if.rst = 1'b0;
        wb_xfer(1'b1, 33, 3, r, a, p);
        wb_xfer(1'b1, 0, 10, r, a, t1);
        poll_ramp(0, 10, t1, p, 25, -1);
        wb_read(0, r);
        checks++; if (r !== 32'h000A_000A) begin errors++; $display("FAIL ramp_up_done got %h want 000a000a", r); end
        wb_xfer(1'b1, 0, 0, r, a, t2);
        poll_ramp(10, 0, t2, p, 25, -1);
        wb_xfer(1'b1, 0, 10, r, a, t3);
        poll_ramp(0, 10, t3, p, 25, 7);
        wb_xfer(1'b1, 0, 4, r, a, w);
        v0 = ramp_val(0, 10, t3, w, p);
        poll_ramp(v0, 4, w, p, 14, -1);
        wb_read(0, r);
        checks++; if (r !== 32'h0004_0004) begin errors++; $display("FAIL ramp_redirect_done got %h want 00040004", r); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] r;
        int          ones;
        wb_write(33, 0);
        wb_write(32, 1);
        wb_write(0, 200);
        repeat (20) @(negedge clk);
        @(negedge clk);
        wb_if.stb = 1'b1;
        wb_if.we  = 1'b0;
        wb_if.adr = 32'd0;
        wb_if.rst = 1'b1;
        @(negedge clk);
        wb_if.stb = 1'b0;
        checks++; if (wb_if.ack !== 1'b0) begin errors++; $display("FAIL midreset_ack got %b want 0", wb_if.ack); end
        checks++; if (wb_if.dat_p !== 32'h0) begin errors++; $display("FAIL midreset_datp got %h want 0", wb_if.dat_p); end
        checks++; if (pdm !== '0) begin errors++; $display("FAIL midreset_pdm got %h want 0", pdm); end
        wb_if.rst = 1'b0;
        wb_read(0, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL midreset_ch0 got %h want 0", r); end
        wb_read(32, r);
        checks++; if (r !== 32'h0) begin errors++; $display("FAIL midreset_enable got %h want 0", r); end
        ones = 0;
        repeat (20) begin
            @(negedge clk);
            ones += int'(pdm != '0);
        end
        checks++; if (ones !== 0) begin errors++; $display("FAIL midreset_quiet got %0d want 0", ones); end
    endtask

    initial begin
        wb_if.rst   = 1'b1;
        wb_if.stb   = 1'b0;
        wb_if.we    = 1'b0;
        wb_if.adr   = 32'd0;
        wb_if.dat_c = 32'd0;
        test_reset();
        test_regs();
        test_back_to_back();
        test_duty();
        test_enable();
        test_random();
`ifdef PDM_BANK_RAMP_EN
        test_ramp();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
